// File: rtl/alu_share_arbiter.sv
// Round-robin share of one 32-bit combinational ALU between two requesters.
// Optional ALU_ARB_STATS_EN adds grant and conflict counters.
module alu #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 3
) (
  input  logic [OP_W-1:0]   i_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_y
);
  always_comb begin
    o_y = '0;
    unique case (i_op)
      3'b000: o_y = i_a + i_b;
      3'b001: o_y = i_a - i_b;
      3'b010: o_y = i_a & i_b;
      3'b011: o_y = i_a | i_b;
      3'b100: o_y = i_a ^ i_b;
      3'b101: o_y = {{(DATA_W-1){1'b0}},
                     $signed(i_a) < $signed(i_b)};
      3'b110: o_y = {{(DATA_W-1){1'b0}}, i_a < i_b};
      default: o_y = '0;
    endcase
  end
endmodule

module alu_share_arbiter #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  output logic              resp0_valid,
  input  logic              resp0_ready,
  output logic [DATA_W-1:0] resp0_data,
  output logic              resp0_err,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              resp1_valid,
  input  logic              resp1_ready,
  output logic [DATA_W-1:0] resp1_data,
  output logic              resp1_err
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0]       grant_cnt0,
  output logic [15:0]       grant_cnt1,
  output logic [15:0]       conflict_cnt
`endif
);
  localparam logic [OP_W-1:0] OP_RSV = 3'b111;

  logic              r_v0, r_v1, r_e0, r_e1;
  logic [DATA_W-1:0] r_d0, r_d1;
  logic              r_last;
  logic              w_el0, w_el1, w_g0, w_g1;
  logic [OP_W-1:0]   w_op;
  logic [DATA_W-1:0] w_a, w_b, w_y, w_res;
  logic              w_rsv;

  assign w_el0 = req0_valid && (!r_v0 || resp0_ready);
  assign w_el1 = req1_valid && (!r_v1 || resp1_ready);

  // On a tie the requester that did not win last time goes first
  assign w_g0 = !reset && w_el0 && (!w_el1 || r_last);
  assign w_g1 = !reset && w_el1 && (!w_el0 || !r_last);

  assign req0_ready = w_g0;
  assign req1_ready = w_g1;

  assign w_op = w_g1 ? req1_op : req0_op;
  assign w_a  = w_g1 ? req1_a  : req0_a;
  assign w_b  = w_g1 ? req1_b  : req0_b;

  alu #(.DATA_W(DATA_W), .OP_W(OP_W)) u_alu (
    .i_op (w_op),
    .i_a  (w_a),
    .i_b  (w_b),
    .o_y  (w_y)
  );

  assign w_rsv = (w_op == OP_RSV);
  assign w_res = w_rsv ? '0 : w_y;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_v0   <= 1'b0;
      r_v1   <= 1'b0;
      r_d0   <= '0;
      r_d1   <= '0;
      r_e0   <= 1'b0;
      r_e1   <= 1'b0;
      r_last <= 1'b1;
    end else begin
      if (w_g0) begin
        r_d0   <= w_res;
        r_e0   <= w_rsv;
        r_v0   <= 1'b1;
        r_last <= 1'b0;
      end else if (r_v0 && resp0_ready) begin
        r_v0 <= 1'b0;
      end
      if (w_g1) begin
        r_d1   <= w_res;
        r_e1   <= w_rsv;
        r_v1   <= 1'b1;
        r_last <= 1'b1;
      end else if (r_v1 && resp1_ready) begin
        r_v1 <= 1'b0;
      end
    end
  end

  assign resp0_valid = r_v0;
  assign resp0_data  = r_d0;
  assign resp0_err   = r_e0;
  assign resp1_valid = r_v1;
  assign resp1_data  = r_d1;
  assign resp1_err   = r_e1;

`ifdef ALU_ARB_STATS_EN
  logic [15:0] r_gc0, r_gc1, r_cc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_gc0 <= '0;
      r_gc1 <= '0;
      r_cc  <= '0;
    end else begin
      if (w_g0) r_gc0 <= r_gc0 + 16'd1;
      if (w_g1) r_gc1 <= r_gc1 + 16'd1;
      if (w_el0 && w_el1) r_cc <= r_cc + 16'd1;
    end
  end

  assign grant_cnt0   = r_gc0;
  assign grant_cnt1   = r_gc1;
  assign conflict_cnt = r_cc;
`endif
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized and directed bench for alu_share_arbiter.
// Reference model tracks slots, round-robin pointer and counters.
module tb_alu_share_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        v0 = 0, v1 = 0, rr0 = 0, rr1 = 0;
  logic [2:0]  op0 = 0, op1 = 0;
  logic [31:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
  logic        rdy0, rdy1, rv0, rv1, re0, re1;
  logic [31:0] rd0, rd1;
`ifdef ALU_ARB_STATS_EN
  logic [15:0] gc0, gc1, cc;
`endif

  always #5 clk = ~clk;

  alu_share_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(v0), .req0_ready(rdy0),
    .req0_op(op0), .req0_a(a0), .req0_b(b0),
    .resp0_valid(rv0), .resp0_ready(rr0),
    .resp0_data(rd0), .resp0_err(re0),
    .req1_valid(v1), .req1_ready(rdy1),
    .req1_op(op1), .req1_a(a1), .req1_b(b1),
    .resp1_valid(rv1), .resp1_ready(rr1),
    .resp1_data(rd1), .resp1_err(re1)
`ifdef ALU_ARB_STATS_EN
    , .grant_cnt0(gc0), .grant_cnt1(gc1),
    .conflict_cnt(cc)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model state
  bit        m_v[2];
  bit [31:0] m_d[2];
  bit        m_e[2];
  int        m_last = 1;
  int        m_gc[2];
  int        m_cc = 0;
  bit        s_rdy0, s_rdy1;

  task automatic chk(input string n,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  function automatic bit [31:0] ref_alu(
      input bit [2:0] op, input bit [31:0] a,
      input bit [31:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ($signed(a) < $signed(b)) ? 1 : 0;
      3'd6: return (a < b) ? 1 : 0;
      default: return 0;
    endcase
  endfunction

  // One clock: check ready, advance model, check responses
  task automatic step();
    bit e0, e1, g0, g1, q0, q1;
    #2;
    e0 = v0 && (!m_v[0] || rr0);
    e1 = v1 && (!m_v[1] || rr1);
    g0 = 0; g1 = 0;
    if (!reset) begin
      if (e0 && e1) begin
        if (m_last == 1) g0 = 1; else g1 = 1;
      end else begin
        g0 = e0; g1 = e1;
      end
    end
    s_rdy0 = rdy0; s_rdy1 = rdy1;
    chk("ready0", {31'd0, rdy0}, {31'd0, g0});
    chk("ready1", {31'd0, rdy1}, {31'd0, g1});
    q0 = rr0; q1 = rr1;
    @(posedge clk);
    if (reset) begin
      m_v = '{0, 0}; m_d = '{0, 0}; m_e = '{0, 0};
      m_last = 1; m_gc = '{0, 0}; m_cc = 0;
    end else begin
      if (e0 && e1) m_cc = (m_cc + 1) % 65536;
      if (g0) begin
        m_d[0] = ref_alu(op0, a0, b0);
        m_e[0] = (op0 == 3'd7);
        m_v[0] = 1; m_last = 0;
        m_gc[0] = (m_gc[0] + 1) % 65536;
      end else if (m_v[0] && q0) m_v[0] = 0;
      if (g1) begin
        m_d[1] = ref_alu(op1, a1, b1);
        m_e[1] = (op1 == 3'd7);
        m_v[1] = 1; m_last = 1;
        m_gc[1] = (m_gc[1] + 1) % 65536;
      end else if (m_v[1] && q1) m_v[1] = 0;
    end
    #1;
    chk("resp0_valid", {31'd0, rv0}, {31'd0, m_v[0]});
    chk("resp1_valid", {31'd0, rv1}, {31'd0, m_v[1]});
    chk("resp0_data", rd0, m_d[0]);
    chk("resp1_data", rd1, m_d[1]);
    chk("resp0_err", {31'd0, re0}, {31'd0, m_e[0]});
    chk("resp1_err", {31'd0, re1}, {31'd0, m_e[1]});
`ifdef ALU_ARB_STATS_EN
    chk("grant_cnt0", {16'd0, gc0}, m_gc[0]);
    chk("grant_cnt1", {16'd0, gc1}, m_gc[1]);
    chk("conflict_cnt", {16'd0, cc}, m_cc);
`endif
  endtask

  task automatic do_reset();
    reset = 1; step(); reset = 0;
  endtask

  initial begin
    @(posedge clk); #1;
    v0 = 0; v1 = 0; rr0 = 1; rr1 = 1;
    do_reset();
    step();
    chk("idle_rv0", {31'd0, rv0}, 0);
    chk("idle_rd0", rd0, 0);
    chk("idle_rdy0", {31'd0, s_rdy0}, 0);

    // Single ADD wrapping modulo 2^32
    v0 = 1; op0 = 3'd0; a0 = 32'hFFFF_FFFF; b0 = 2;
    step();
    chk("add_rdy", {31'd0, s_rdy0}, 1);
    chk("add_data", rd0, 32'h1);
    chk("add_err", {31'd0, re0}, 0);
    v0 = 0; step();

    // Tie round-robin from reset
    do_reset();
    v0 = 1; op0 = 3'd1; a0 = 5; b0 = 7;
    v1 = 1; op1 = 3'd5; a1 = 32'hFFFF_FFFF; b1 = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rr_g0", {31'd0, s_rdy0}, (i % 2 == 0));
      chk("rr_g1", {31'd0, s_rdy1}, (i % 2 == 1));
    end
    chk("rr_d0", rd0, 32'hFFFF_FFFE);
    chk("rr_d1", rd1, 32'h1);
    v0 = 0; v1 = 0; step();

    // Backpressure on slot 1
    do_reset();
    v1 = 1; op1 = 3'd3; a1 = 32'hF0; b1 = 32'h0F; rr1 = 0;
    step();
    chk("bp_fill", rd1, 32'hFF);
    v0 = 1; op0 = 3'd2; a0 = 32'hFF00; b0 = 32'h0FF0;
    op1 = 3'd4; a1 = 32'hAAAA; b1 = 32'h5555;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_no_g1", {31'd0, s_rdy1}, 0);
      chk("bp_g0", {31'd0, s_rdy0}, 1);
    end
    rr1 = 1; step();
    chk("bp_g1", {31'd0, s_rdy1}, 1);
    chk("bp_rv1", {31'd0, rv1}, 1);
    chk("bp_d1", rd1, 32'hFFFF);

    // Reserved op and SLTU
    v0 = 0; v1 = 1; op1 = 3'd7; step();
    chk("rsv_d1", rd1, 0);
    chk("rsv_e1", {31'd0, re1}, 1);
    v1 = 0; v0 = 1; op0 = 3'd6;
    a0 = 32'hFFFF_FFFF; b0 = 1; step();
    chk("sltu_d0", rd0, 0);

    // Reset mid-flight
    op0 = 3'd0; rr0 = 0; step();
    chk("mid_rv0", {31'd0, rv0}, 1);
    v0 = 0; do_reset();
    chk("mid_rv0_rst", {31'd0, rv0}, 0);
    v0 = 1; v1 = 1; rr0 = 1; rr1 = 1; step();
    chk("mid_tie0", {31'd0, s_rdy0}, 1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      v0 = $urandom_range(0, 3) != 0;
      v1 = $urandom_range(0, 3) != 0;
      rr0 = $urandom_range(0, 2) != 0;
      rr1 = $urandom_range(0, 2) != 0;
      op0 = 3'($urandom); op1 = 3'($urandom);
      a0 = $urandom; b0 = $urandom;
      a1 = $urandom; b1 = $urandom;
      if ($urandom_range(0, 3) == 0) b0 = a0;
      if ($urandom_range(0, 3) == 0) a1 = 32'h8000_0000;
      step();
    end
    reset = 0;

`ifdef ALU_ARB_STATS_EN
    do_reset();
    v0 = 1; v1 = 0; rr0 = 1; op0 = 3'd0;
    for (int i = 0; i < 3; i++) step();
    chk("stat_gc0_3", {16'd0, gc0}, 3);
    for (int i = 0; i < 65533; i++) step();
    chk("stat_gc0_wrap", {16'd0, gc0}, 0);
`endif

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end
endmodule
